// File: rtl/ifetch_queue_if.sv
// ifetch_queue_if
// Groups the fetch-side signals of ifetch_queue into one bundle.
//   imem_req_valid/imem_req_ready/imem_addr : fetch request to instruction memory
//   imem_rsp_valid/imem_rsp_data            : in-order fetch responses
//   redirect_valid/redirect_pc              : branch/jump redirect from execute
//   instr_valid/instr_ready/instr/instr_pc  : queue head towards decode
//   stall_cnt                               : decode-starve cycle counter
// Modport master is the queue itself; slave is memory/decode/execute.
interface ifetch_queue_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] stall_cnt;

    modport master (
        output imem_req_valid, imem_addr, instr_valid, instr, instr_pc, stall_cnt,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, instr_ready
    );

    modport slave (
        input  imem_req_valid, imem_addr, instr_valid, instr, instr_pc, stall_cnt,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, instr_ready
    );
endinterface

// File: rtl/ifetch_queue.sv
// ifetch_queue
// Instruction fetch unit with a small in-order instruction queue. Requests
// are issued only while queue occupancy plus outstanding requests leave room
// for every response, so a response never finds the queue full. A redirect
// flushes the queue and marks all outstanding responses to be discarded.
// Ports:
//   clk    : single clock, all state on posedge
//   reset  : synchronous, active-high
//   bus    : ifetch_queue_if.master (memory request/response, redirect,
//            decode head, stall counter)
// Optional build macro IFETCH_QUEUE_STALL_CNT_EN: enables the decode-starve
// counter on stall_cnt; otherwise stall_cnt is tied to zero.
module ifetch_queue #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset,
    ifetch_queue_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

    logic [31:0]      r_pc;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_inflight;
    logic [CNT_W-1:0] r_drop;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [31:0]      r_q_instr [DEPTH];
    logic [31:0]      r_q_pc    [DEPTH];
    logic [31:0]      r_last_instr;
    logic [31:0]      r_last_pc;

    logic w_credit_ok;
    logic w_req_valid;
    logic w_req_fire;
    logic w_rsp_acc;
    logic w_push;
    logic w_instr_valid;
    logic w_pop;
    logic w_unused;

    assign w_credit_ok   = ({1'b0, r_count} + {1'b0, r_inflight}) < DEPTH_C;
    assign w_req_valid   = !reset && !bus.redirect_valid && w_credit_ok;
    assign w_req_fire    = w_req_valid && bus.imem_req_ready;
    // A response with nothing outstanding is spurious and ignored entirely.
    assign w_rsp_acc     = bus.imem_rsp_valid && (r_inflight != '0);
    assign w_push        = w_rsp_acc && !bus.redirect_valid && (r_drop == '0);
    assign w_instr_valid = !reset && (r_count != '0);
    assign w_pop         = w_instr_valid && bus.instr_ready && !bus.redirect_valid;

    // Redirect target is forced word aligned; low bits are deliberately dropped.
    assign w_unused = ^bus.redirect_pc[1:0];

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_addr      = r_pc;
    assign bus.instr_valid    = w_instr_valid;
    // Empty queue keeps showing the last head so the immediate extender sees stable bits.
    assign bus.instr          = w_instr_valid ? r_q_instr[r_rd_ptr] : r_last_instr;
    assign bus.instr_pc       = w_instr_valid ? r_q_pc[r_rd_ptr]    : r_last_pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc         <= RESET_PC;
            r_count      <= '0;
            r_inflight   <= '0;
            r_drop       <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_last_instr <= '0;
            r_last_pc    <= '0;
        end else begin
            unique case ({w_req_fire, w_rsp_acc})
                2'b10:   r_inflight <= r_inflight + CNT_W'(1);
                2'b01:   r_inflight <= r_inflight - CNT_W'(1);
                default: r_inflight <= r_inflight;
            endcase

            if (w_instr_valid) begin
                r_last_instr <= r_q_instr[r_rd_ptr];
                r_last_pc    <= r_q_pc[r_rd_ptr];
            end

            if (bus.redirect_valid) begin
                // Everything still outstanding after this cycle belongs to the old path.
                r_pc     <= {bus.redirect_pc[31:2], 2'b00};
                r_count  <= '0;
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_drop   <= r_inflight - CNT_W'(w_rsp_acc);
            end else begin
                if (w_req_fire) begin
                    r_pc <= r_pc + 32'd4;
                end
                if (w_rsp_acc && (r_drop != '0)) begin
                    r_drop <= r_drop - CNT_W'(1);
                end
                if (w_push) begin
                    r_q_instr[r_wr_ptr] <= bus.imem_rsp_data;
                    r_q_pc[r_wr_ptr]    <= r_pc - {r_inflight, 2'b00};
                    r_wr_ptr            <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
                unique case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CNT_W'(1);
                    2'b01:   r_count <= r_count - CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

`ifdef IFETCH_QUEUE_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (!w_instr_valid) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign bus.stall_cnt = r_stall_cnt;
`else
    assign bus.stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
module tb_ifetch_queue;
    logic clk = 1'b0;
    logic reset;

    ifetch_queue_if bus();

    ifetch_queue #(.DEPTH(2), .RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        mrdy;
        logic        rspen;
        logic        irdy;
        logic        rv;
        logic [31:0] rpc;
        logic        chk;
        logic        e_iv;
        logic        e_rqv;
        logic [31:0] e_addr;
        logic [31:0] e_ipc;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    int          n_pass = 0;
    int          n_total = 0;
    logic [31:0] pend_q[$];
    exp_t        exp_q[$];
    logic [31:0] m_pc = 32'h0;
    logic        spurious = 1'b0;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    function automatic vec_t mk(input logic rst, input logic mrdy, input logic rspen,
                                input logic irdy, input logic rv, input logic [31:0] rpc,
                                input logic chk, input logic e_iv, input logic e_rqv,
                                input logic [31:0] e_addr, input logic [31:0] e_ipc);
        vec_t v;
        v.rst = rst; v.mrdy = mrdy; v.rspen = rspen; v.irdy = irdy; v.rv = rv; v.rpc = rpc;
        v.chk = chk; v.e_iv = e_iv; v.e_rqv = e_rqv; v.e_addr = e_addr; v.e_ipc = e_ipc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
    endtask

    // One cycle: drive at negedge, settle, check, then account for the coming posedge.
    task automatic step(input vec_t v, input string tag);
        exp_t e;
        @(negedge clk);
        reset              = v.rst;
        bus.imem_req_ready = v.mrdy;
        bus.instr_ready    = v.irdy;
        bus.redirect_valid = v.rv;
        bus.redirect_pc    = v.rpc;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        if (v.rst) begin
            pend_q.delete();
            exp_q.delete();
            m_pc = 32'h0;
        end else if (v.rspen && pend_q.size() > 0) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mdata(pend_q.pop_front());
        end else if (spurious) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = $urandom;
        end
        #1;
        if (v.chk) begin
            chk({tag, " instr_valid"}, 32'(bus.instr_valid), 32'(v.e_iv));
            chk({tag, " req_valid"}, 32'(bus.imem_req_valid), 32'(v.e_rqv));
            chk({tag, " imem_addr"}, bus.imem_addr, v.e_addr);
            chk({tag, " instr_pc"}, bus.instr_pc, v.e_ipc);
        end
        if (!v.rst) begin
            if (bus.instr_valid && v.irdy && !v.rv) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL sb_pop: popped pc %h but scoreboard is empty", bus.instr_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_pc", bus.instr_pc, e.pc);
                    chk("sb_instr", bus.instr, e.data);
                end
            end
            if (bus.imem_req_valid && v.mrdy) begin
                chk("fetch_addr", bus.imem_addr, m_pc);
                pend_q.push_back(bus.imem_addr);
                e.pc = m_pc;
                e.data = mdata(m_pc);
                exp_q.push_back(e);
                m_pc = m_pc + 32'd4;
            end
            if (v.rv) begin
                exp_q.delete();
                m_pc = {v.rpc[31:2], 2'b00};
            end
        end
    endtask

    task automatic do_reset();
        step(mk(1,1,1,0,0,0, 0,0,0,0,0), "rst");
        step(mk(1,1,1,0,0,0, 0,0,0,0,0), "rst");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl[$];
        int   first;
        vec_t v;

        reset = 1'b1;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.instr_ready    = 1'b0;

        //            rst m s i rv rpc       chk iv rq addr       ipc
        tbl.push_back(mk(1,1,1,0,0,32'h0,    0, 0,0,32'h0,    32'h0));
        tbl.push_back(mk(1,1,1,0,0,32'h0,    1, 0,0,32'h0,    32'h0));
        // decode stalled: exactly two requests, then queue full
        tbl.push_back(mk(0,1,1,0,0,32'h0,    1, 0,1,32'h0,    32'h0));
        tbl.push_back(mk(0,1,1,0,0,32'h0,    1, 0,1,32'h4,    32'h0));
        tbl.push_back(mk(0,1,1,0,0,32'h0,    1, 1,0,32'h8,    32'h0));
        tbl.push_back(mk(0,1,1,0,0,32'h0,    1, 1,0,32'h8,    32'h0));
        tbl.push_back(mk(0,1,1,1,0,32'h0,    1, 1,0,32'h8,    32'h0));
        tbl.push_back(mk(0,1,1,0,0,32'h0,    1, 1,1,32'h8,    32'h4));
        tbl.push_back(mk(0,1,1,0,0,32'h0,    1, 1,0,32'hC,    32'h4));
        tbl.push_back(mk(0,1,1,0,0,32'h0,    1, 1,0,32'hC,    32'h4));
        // redirect with pop, unaligned target
        tbl.push_back(mk(0,1,1,1,1,32'h103,  1, 1,0,32'hC,    32'h4));
        tbl.push_back(mk(0,1,1,1,0,32'h0,    1, 0,1,32'h100,  32'h4));
        tbl.push_back(mk(0,1,1,1,0,32'h0,    1, 0,1,32'h104,  32'h4));
        tbl.push_back(mk(0,1,1,1,0,32'h0,    1, 1,0,32'h108,  32'h100));
        tbl.push_back(mk(0,1,1,1,0,32'h0,    1, 1,1,32'h108,  32'h104));
        tbl.push_back(mk(0,1,1,1,0,32'h0,    1, 0,1,32'h10C,  32'h104));
        // two in flight, redirect to 0x100, both responses dropped
        tbl.push_back(mk(0,1,0,1,0,32'h0,    1, 1,0,32'h110,  32'h108));
        tbl.push_back(mk(0,1,0,1,0,32'h0,    1, 0,1,32'h110,  32'h108));
        tbl.push_back(mk(0,1,0,1,1,32'h100,  1, 0,0,32'h114,  32'h108));
        tbl.push_back(mk(0,1,1,1,0,32'h0,    1, 0,0,32'h100,  32'h108));
        tbl.push_back(mk(0,1,1,1,0,32'h0,    1, 0,1,32'h100,  32'h108));
        tbl.push_back(mk(0,1,1,1,0,32'h0,    1, 0,1,32'h104,  32'h108));
        tbl.push_back(mk(0,1,1,0,0,32'h0,    1, 1,0,32'h108,  32'h100));
        tbl.push_back(mk(0,1,1,0,0,32'h0,    1, 1,0,32'h108,  32'h100));
        tbl.push_back(mk(0,1,1,1,0,32'h0,    1, 1,0,32'h108,  32'h100));
        tbl.push_back(mk(0,1,0,1,0,32'h0,    1, 1,1,32'h108,  32'h104));
        tbl.push_back(mk(0,1,0,1,0,32'h0,    1, 0,1,32'h10C,  32'h104));
        // redirect coincident with a response: drop=1, later response dropped
        tbl.push_back(mk(0,1,1,1,1,32'h200,  1, 0,0,32'h110,  32'h104));
        tbl.push_back(mk(0,1,1,1,0,32'h0,    1, 0,1,32'h200,  32'h104));
        tbl.push_back(mk(0,1,1,1,0,32'h0,    1, 0,1,32'h204,  32'h104));
        tbl.push_back(mk(0,1,1,1,0,32'h0,    1, 1,0,32'h208,  32'h200));
        tbl.push_back(mk(0,1,1,1,0,32'h0,    1, 1,1,32'h208,  32'h204));
        // back-to-back redirects, last wins
        tbl.push_back(mk(0,1,1,1,1,32'h300,  1, 0,0,32'h20C,  32'h204));
        tbl.push_back(mk(0,1,1,1,1,32'h400,  1, 0,0,32'h300,  32'h204));
        tbl.push_back(mk(0,1,1,1,0,32'h0,    1, 0,1,32'h400,  32'h204));
        tbl.push_back(mk(0,1,1,1,0,32'h0,    1, 0,1,32'h404,  32'h204));
        tbl.push_back(mk(0,1,1,1,0,32'h0,    1, 1,0,32'h408,  32'h400));
        // reset mid-operation overrides redirect and pop
        tbl.push_back(mk(1,1,1,1,1,32'h500,  0, 0,0,32'h0,    32'h0));
        tbl.push_back(mk(1,1,1,1,0,32'h0,    1, 0,0,32'h0,    32'h0));
        tbl.push_back(mk(0,1,1,1,0,32'h0,    1, 0,1,32'h0,    32'h0));

        foreach (tbl[k]) begin
            step(tbl[k], $sformatf("vec%0d", k));
            if (k == 1) chk("reset instr", bus.instr, 32'h0);
        end

        // streaming after reset: first instr_valid two cycles after release
        do_reset();
        first = -1;
        for (int k = 0; k < 10; k++) begin
            step(mk(0,1,1,1,0,0, 0,0,0,0,0), "stream");
            if (bus.instr_valid && first < 0) first = k;
        end
        chk("first_valid_cycle", 32'(first), 32'd2);

        // spurious response with nothing outstanding is ignored
        do_reset();
        spurious = 1'b1;
        step(mk(0,0,1,0,0,0, 0,0,0,0,0), "spur");
        spurious = 1'b0;
        step(mk(0,0,1,0,0,0, 0,0,0,0,0), "spur");
        chk("spurious_ignored", 32'(bus.instr_valid), 32'd0);
        chk("spurious_no_credit", 32'(bus.imem_req_valid), 32'd1);

        // memory stall after reset
        do_reset();
        for (int k = 0; k < 6; k++) step(mk(0,0,1,0,0,0, 0,0,0,0,0), "stall");
`ifdef IFETCH_QUEUE_STALL_CNT_EN
        chk("stall_cnt_min", 32'(bus.stall_cnt >= 32'd5), 32'd1);
`else
        chk("stall_cnt_zero", bus.stall_cnt, 32'd0);
`endif

        // random traffic with occasional redirects
        do_reset();
        for (int k = 0; k < 300; k++) begin
            v = mk(0, ($urandom_range(0,3) != 0), ($urandom_range(0,3) != 0),
                   ($urandom_range(0,2) != 0), ($urandom_range(0,99) < 4), $urandom,
                   0,0,0,0,0);
            step(v, "rand");
            if (v.rv) chk("rqv_under_redirect", 32'(bus.imem_req_valid), 32'd0);
            chk("addr_align", 32'(bus.imem_addr[1:0]), 32'd0);
        end
        for (int k = 0; k < 60; k++) begin
            if (exp_q.size() == 0 && pend_q.size() == 0) break;
            step(mk(0,0,1,1,0,0, 0,0,0,0,0), "drain");
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
`ifndef IFETCH_QUEUE_STALL_CNT_EN
        chk("stall_cnt_zero_end", bus.stall_cnt, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
